lfo_rom_sequencer: RTL and testbench

LFO_ROM_SEQUENCER -- requirements
Module: lfo_rom_sequencer

---
 rtl/lfo_rom_sequencer.sv | 105 ++++++++++
 tb/tb_lfo_rom_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/lfo_rom_sequencer.sv
// LFO sample sequencer: phase accumulator feeding a quarter-wave sine ROM.
// Each accepted tick issues one ROM read.
// The unsigned quarter-wave magnitude is then unfolded into a signed full-wave sample.
module lfo_rom_sequencer #(
   parameter int AWIDTH = 9,
   parameter int DWIDTH = 16,
   parameter int PWIDTH = 24
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     sample_tick_i,
   input  logic [PWIDTH-1:0]        rate_i,
   input  logic                     phase_reset_i,
   output logic [AWIDTH-1:0]        rom_rdaddr_o,
   input  logic [DWIDTH-1:0]        rom_rddata_i,
   output logic signed [DWIDTH:0]   lfo_o,
   output logic                     lfo_valid_o,
   output logic                     busy_o,
   output logic                     overrun_o
);

   typedef enum logic [1:0] {IDLE, ADDR, WAIT} state_e;

   state_e                  state_q;
   logic [PWIDTH-1:0]       phase_q, phase_d;
   logic [1:0]              quad_q;
   logic [AWIDTH-1:0]       addr_q, addr_d;
   logic signed [DWIDTH:0]  lfo_q, lfo_d;
   logic                    vld_q, busy_q, ovr_q;

   logic                    tick_acc;
   logic [PWIDTH-1:0]       rd_phase;
   logic [AWIDTH-1:0]       rd_idx;
   logic [DWIDTH:0]         mag_ext;

   // Next phase, folded ROM address and signed sample for the current cycle
   always_comb begin
      tick_acc = sample_tick_i && (state_q == IDLE);
      // A coincident phase clear makes the read itself start from phase 0
      rd_phase = phase_reset_i ? '0 : phase_q;
      rd_idx   = rd_phase[PWIDTH-3 -: AWIDTH];
      // Quadrants 1 and 3 walk the table backwards: 2^AWIDTH-1-i == ~i
      addr_d   = rd_phase[PWIDTH-2] ? ~rd_idx : rd_idx;
      if (tick_acc)
         phase_d = rd_phase + rate_i;
      else if (phase_reset_i)
         phase_d = '0;
      else
         phase_d = phase_q;
      // One extra bit so full-scale negative fits and -0 stays 0
      mag_ext  = {1'b0, rom_rddata_i};
      lfo_d    = quad_q[1] ? $signed(~mag_ext + 1'b1) : $signed(mag_ext);
   end

   // Sequencer FSM with all outputs registered
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         phase_q <= '0;
         quad_q  <= '0;
         addr_q  <= '0;
         lfo_q   <= '0;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         phase_q <= phase_d;
         vld_q   <= 1'b0;
         // Dropped ticks are remembered until reset
         if (sample_tick_i && (state_q != IDLE))
            ovr_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (tick_acc) begin
                  quad_q  <= rd_phase[PWIDTH-1 -: 2];
                  addr_q  <= addr_d;
                  state_q <= ADDR;
                  busy_q  <= 1'b1;
               end
            end
            ADDR: begin
               // ROM registers the address on this edge
               state_q <= WAIT;
            end
            WAIT: begin
               lfo_q   <= lfo_d;
               vld_q   <= 1'b1;
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rom_rdaddr_o = addr_q;
   assign lfo_o        = lfo_q;
   assign lfo_valid_o  = vld_q;
   assign busy_o       = busy_q;
   assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_lfo_rom_sequencer.sv
// Directed bench for lfo_rom_sequencer with a 1-clock ROM returning data == address.
module tb_lfo_rom_sequencer;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               tick;
   logic [23:0]        rate;
   logic               prst;
   logic [8:0]         rom_addr;
   logic [15:0]        rom_data;
   logic signed [16:0] lfo;
   logic               lfo_vld, busy, ovr;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // ROM model: address registered inside, data equals address
   always_ff @(posedge clk) rom_data <= {7'd0, rom_addr};

   lfo_rom_sequencer dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .sample_tick_i (tick),
      .rate_i        (rate),
      .phase_reset_i (prst),
      .rom_rdaddr_o  (rom_addr),
      .rom_rddata_i  (rom_data),
      .lfo_o         (lfo),
      .lfo_valid_o   (lfo_vld),
      .busy_o        (busy),
      .overrun_o     (ovr)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Assumes entry at a negedge with the block idle; returns at a negedge, idle
   task automatic do_read(input string tag, input logic [23:0] r, input logic pr,
                          input int exp_addr, input int exp_lfo);
      tick = 1'b1; rate = r; prst = pr;
      @(negedge clk);
      tick = 1'b0; prst = 1'b0;
      chk({tag, ".addr"}, int'(rom_addr), exp_addr);
      chk({tag, ".busy"}, int'(busy), 1);
      chk({tag, ".vld1"}, int'(lfo_vld), 0);
      @(negedge clk);
      chk({tag, ".vld2"}, int'(lfo_vld), 0);
      @(negedge clk);
      chk({tag, ".vld3"}, int'(lfo_vld), 1);
      chk({tag, ".lfo"}, int'(lfo), exp_lfo);
      @(negedge clk);
      chk({tag, ".vld4"}, int'(lfo_vld), 0);
      chk({tag, ".idle"}, int'(busy), 0);
      chk({tag, ".hold"}, int'(lfo), exp_lfo);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int pulses;
      tick = 1'b0; rate = '0; prst = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      do_reset();
      chk("rst.addr", int'(rom_addr), 0);
      chk("rst.lfo",  int'(lfo), 0);
      chk("rst.vld",  int'(lfo_vld), 0);
      chk("rst.busy", int'(busy), 0);
      chk("rst.ovr",  int'(ovr), 0);

      // Basic single reads
      do_read("basic0", 24'h002000, 1'b0, 0, 0);
      do_read("basic1", 24'h002000, 1'b0, 1, 1);

      // Four quadrants and wrap
      do_reset();
      do_read("q0", 24'h400000, 1'b0, 0, 0);
      repeat (4) @(negedge clk);
      do_read("q1", 24'h400000, 1'b0, 511, 511);
      repeat (4) @(negedge clk);
      do_read("q2", 24'h400000, 1'b0, 0, 0);
      repeat (4) @(negedge clk);
      do_read("q3", 24'h400000, 1'b0, 511, -511);
      do_read("wrap", 24'h002000, 1'b0, 0, 0);
      // phase now 0x002000; +0x808000 -> 0x80A000: q2, index 5
      do_read("mid_a", 24'h808000, 1'b0, 1, 1);
      do_read("q2i5", 24'h400000, 1'b0, 5, -5);
      do_read("q3i5", 24'h002000, 1'b0, 506, -506);

      // Back-to-back ticks: second dropped, overrun sticky
      do_reset();
      tick = 1'b1; rate = 24'h002000;
      @(negedge clk);
      @(negedge clk);
      tick = 1'b0;
      chk("ovr.set", int'(ovr), 1);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         if (lfo_vld) pulses++;
         @(negedge clk);
      end
      chk("ovr.pulses", pulses, 1);
      chk("ovr.lfo", int'(lfo), 0);
      do_read("ovr.next", 24'h002000, 1'b0, 1, 1);
      chk("ovr.sticky", int'(ovr), 1);

      // Phase clear coinciding with a tick
      do_reset();
      do_read("pr.setup", 24'h300000, 1'b0, 0, 0);
      do_read("pr.tick", 24'h002000, 1'b1, 0, 0);
      do_read("pr.next", 24'h002000, 1'b0, 1, 1);

      // Reset during WAIT discards the read
      do_reset();
      do_read("ab.a", 24'h002000, 1'b0, 0, 0);
      do_read("ab.b", 24'h002000, 1'b0, 1, 1);
      tick = 1'b1; rate = 24'h002000;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("ab.addr", int'(rom_addr), 0);
      chk("ab.lfo",  int'(lfo), 0);
      chk("ab.busy", int'(busy), 0);
      chk("ab.vld",  int'(lfo_vld), 0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (lfo_vld) pulses++;
      end
      chk("ab.nopulse", pulses, 0);
      do_read("ab.next", 24'h002000, 1'b0, 0, 0);

      // rate change while busy only affects the next accepted tick
      do_reset();
      tick = 1'b1; rate = 24'h002000;
      @(negedge clk);
      tick = 1'b0; rate = 24'h100000;
      @(negedge clk);
      @(negedge clk);
      chk("rc.vld", int'(lfo_vld), 1);
      chk("rc.lfo", int'(lfo), 0);
      @(negedge clk);
      do_read("rc.b", 24'h100000, 1'b0, 1, 1);
      do_read("rc.c", 24'h002000, 1'b0, 129, 129);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
